// File: rtl/pos_tablo_tarayici.sv
// pos_tablo_tarayici
// Sweeps a combinational N_IN-input function through all 2**N_IN input
// vectors. Each vector is held for SETTLE cycles, then x_in is sampled
// for one cycle. The sampled bits build the captured truth table, which
// is checked against a golden mask that is latched at start.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a scan (accepted only in IDLE, abort has priority)
//   abort      cancel an active scan; returns to IDLE with no done pulse
//   expected   golden truth table, bit k = required output for vector k
//   vec_out    registered drive to the function inputs (MSB = a)
//   x_in       function output
//   busy       scan in progress (SETTLE/SAMPLE)
//   done       one-cycle completion pulse
//   result     captured table, bit k = x_in sampled while vec_out = k
//   match      captured table equals expected; valid from done
//   err_count  number of mismatching minterms
//   first_err  lowest mismatching index, 0 when none (qualify with match)
module pos_tablo_tarayici #(
  parameter  int unsigned N_IN   = 4,
  parameter  int unsigned SETTLE = 1,
  localparam int unsigned W      = 2**N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [W-1:0]      expected,
  output logic [N_IN-1:0]   vec_out,
  input  logic              x_in,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      result,
  output logic              match,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_FIN
  } state_e;

  localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = '1;
  localparam logic [N_IN-1:0] IDX_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   ERR_ONE  = {{N_IN{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [W-1:0]      exp_q, exp_d;
  logic [W-1:0]      result_q, result_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   ferr_q, ferr_d;
  logic              match_q, match_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      err_q    <= '0;
      ferr_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      err_q    <= err_d;
      ferr_q   <= ferr_d;
      match_q  <= match_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    result_d = result_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    match_d  = match_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          exp_d    = expected;
          result_d = '0;
          err_d    = '0;
          ferr_d   = '0;
          match_d  = 1'b0;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          match_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_SAMPLE: begin
        // abort beats the sample: the minterm under test is not recorded
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          match_d = 1'b0;
        end else begin
          result_d[idx_q] = x_in;
          if (x_in != exp_q[idx_q]) begin
            err_d = err_q + ERR_ONE;
            if (err_q == '0) begin
              ferr_d = idx_q;
            end
          end
          if (idx_q == IDX_LAST) begin
            // match includes the last minterm's comparison
            match_d = (err_d == '0);
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_SETTLE;
          end
        end
      end

      S_FIN: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign vec_out   = idx_q;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_FIN);
  assign result    = result_q;
  assign match     = match_q;
  assign err_count = err_q;
  assign first_err = ferr_q;

endmodule

// File: tb/tb_pos_tablo_tarayici.sv
module tb_pos_tablo_tarayici;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // instance A: SETTLE=1, function combinational on vec_out
  logic        start_a, abort_a;
  logic [15:0] exp_a;
  logic [3:0]  vec_a;
  logic        x_a, busy_a, done_a, match_a;
  logic [15:0] res_a;
  logic [4:0]  errc_a;
  logic [3:0]  ferr_a;

  // instance B: SETTLE=3, function output delayed 2 cycles
  logic        start_b, abort_b;
  logic [15:0] exp_b;
  logic [3:0]  vec_b, vb1, vb2;
  logic        x_b, busy_b, done_b, match_b;
  logic [15:0] res_b;
  logic [4:0]  errc_b;
  logic [3:0]  ferr_b;

  // lab POS network: zeros at 0,1,2,3,4,8,10,12,14
  function automatic logic fmod(input logic [3:0] v);
    return (v[3] & v[0]) | (~v[3] & v[2] & (v[1] | v[0]));
  endfunction

  assign x_a = fmod(vec_a);

  always @(posedge clk) begin
    vb1 <= vec_b;
    vb2 <= vb1;
  end
  assign x_b = fmod(vb2);

  pos_tablo_tarayici #(.N_IN(4), .SETTLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .expected(exp_a), .vec_out(vec_a), .x_in(x_a), .busy(busy_a),
    .done(done_a), .result(res_a), .match(match_a),
    .err_count(errc_a), .first_err(ferr_a)
  );

  pos_tablo_tarayici #(.N_IN(4), .SETTLE(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .expected(exp_b), .vec_out(vec_b), .x_in(x_b), .busy(busy_b),
    .done(done_b), .result(res_b), .match(match_b),
    .err_count(errc_b), .first_err(ferr_b)
  );

  int unsigned n_tot = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start on A, follow the scan, report done cycle (relative to the
  // accepting edge, -1 on timeout) and count vec_out/busy walk violations.
  task automatic scan_a(input logic [15:0] e, input bit inj,
                        output int done_at, output int walkbad);
    done_at = -1;
    walkbad = 0;
    exp_a   = e;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    exp_a   = ~e;  // port changes during the scan must not matter
    if (vec_a != 4'd0 || !busy_a) walkbad++;
    for (int j = 1; j <= 200; j++) begin
      tick();
      start_a = inj && (j == 5 || j == 12 || j == 20);
      if (done_a) begin
        done_at = j;
        break;
      end
      if (vec_a != 4'(j / 2) || !busy_a) walkbad++;
    end
    start_a = 1'b0;
  endtask

  int d_at, wb, ndone, dpos0, dpos1;

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; exp_a = '0;
    start_b = 1'b0; abort_b = 1'b0; exp_b = '0;
    #12;
    chk("rst_vec", vec_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_res", res_a, 0);
    chk("rst_match", match_a, 0);
    chk("rst_err", errc_a, 0);
    chk("rst_ferr", ferr_a, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // 1: golden pass
    scan_a(16'hAAE0, 1'b0, d_at, wb);
    chk("t1_done_at", d_at, 32);
    chk("t1_walk", wb, 0);
    chk("t1_busy_fin", busy_a, 0);
    chk("t1_res", res_a, 16'hAAE0);
    chk("t1_match", match_a, 1);
    chk("t1_err", errc_a, 0);
    chk("t1_ferr", ferr_a, 0);
    tick();
    chk("t1_done_pulse", done_a, 0);
    tick(); tick();
    chk("t1_res_hold", res_a, 16'hAAE0);
    chk("t1_match_hold", match_a, 1);

    // 2: two mismatches at minterms 0 and 15
    scan_a(16'h2AE1, 1'b0, d_at, wb);
    chk("t2_done_at", d_at, 32);
    chk("t2_res", res_a, 16'hAAE0);
    chk("t2_err", errc_a, 2);
    chk("t2_ferr", ferr_a, 0);
    chk("t2_match", match_a, 0);
    tick();

    // 2b: single mismatch at minterm 3
    scan_a(16'hAAE8, 1'b0, d_at, wb);
    chk("t2b_err", errc_a, 1);
    chk("t2b_ferr", ferr_a, 3);
    chk("t2b_match", match_a, 0);
    tick();

    // 3: abort on the edge where minterm 4 would be sampled
    exp_a = 16'h000F;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int j = 1; j <= 9; j++) tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("t3_busy", busy_a, 0);
    chk("t3_vec", vec_a, 0);
    chk("t3_done", done_a, 0);
    chk("t3_match", match_a, 0);
    chk("t3_res_part", res_a, 16'h0000);
    chk("t3_err_part", errc_a, 4);
    ndone = 0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (done_a || busy_a) ndone++;
    end
    chk("t3_quiet", ndone, 0);
    // start and abort together in IDLE: abort wins
    start_a = 1'b1;
    abort_a = 1'b1;
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("t3_sa_busy", busy_a, 0);
    tick();
    scan_a(16'hAAE0, 1'b0, d_at, wb);
    chk("t3_fresh_at", d_at, 32);
    chk("t3_fresh_match", match_a, 1);
    tick();

    // 4a: extra start pulses mid-scan
    scan_a(16'hAAE0, 1'b1, d_at, wb);
    chk("t4_inj_at", d_at, 32);
    chk("t4_inj_walk", wb, 0);
    chk("t4_inj_res", res_a, 16'hAAE0);
    chk("t4_inj_match", match_a, 1);
    tick();

    // 4b: start held high for 80 cycles
    exp_a = 16'hAAE0;
    start_a = 1'b1;
    tick();
    ndone = 0; dpos0 = -1; dpos1 = -1;
    for (int j = 1; j <= 80; j++) begin
      tick();
      if (done_a) begin
        if (ndone == 0) dpos0 = j;
        else if (ndone == 1) dpos1 = j;
        ndone++;
      end
    end
    start_a = 1'b0;
    chk("t4_ndone", ndone, 2);
    chk("t4_done0", dpos0, 32);
    chk("t4_done1", dpos1, 66);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("t4_abort_busy", busy_a, 0);
    tick();

    // 5: asynchronous reset mid-scan
    exp_a = 16'hAAE0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int j = 1; j <= 17; j++) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("t5_vec", vec_a, 0);
    chk("t5_busy", busy_a, 0);
    chk("t5_done", done_a, 0);
    chk("t5_res", res_a, 0);
    chk("t5_err", errc_a, 0);
    chk("t5_ferr", ferr_a, 0);
    chk("t5_match", match_a, 0);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (busy_a || done_a || vec_a != 4'd0) ndone++;
    end
    chk("t5_idle", ndone, 0);

    // 6: SETTLE=3 with delayed function output
    exp_b = 16'hAAE0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    d_at = -1;
    wb = 0;
    if (vec_b != 4'd0) wb++;
    for (int j = 1; j <= 200; j++) begin
      tick();
      if (done_b) begin
        d_at = j;
        break;
      end
      if (vec_b != 4'(j / 4) || !busy_b) wb++;
    end
    chk("t6_done_at", d_at, 64);
    chk("t6_walk", wb, 0);
    chk("t6_res", res_b, 16'hAAE0);
    chk("t6_match", match_b, 1);
    chk("t6_err", errc_b, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
